// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1-style UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN to vote each bit sample over the last three ticks.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_16x_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    state_t               state, state_nx;
    logic [3:0]           tick_cnt, tick_cnt_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic                 rx_q, rx_s, bit_s, stop_smp, load;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) {rx_s, rx_q} <= 2'b11;
        else        {rx_s, rx_q} <= {rx_q, rx_i};

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)          hist <= 2'b11;
        else if (tick_16x_i) hist <= {hist[0], rx_s};
    assign bit_s = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_s = rx_s;
`endif

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_idx_nx  = bit_idx;
        shift_nx    = shift;
        stop_smp    = 1'b0;
        if (tick_16x_i) begin
            if (state inside {START, DATA, STOP}) tick_cnt_nx = tick_cnt + 4'd1;
            case (state)
                IDLE: if (!rx_s) begin
                    state_nx    = START;
                    tick_cnt_nx = '0;
                end
                START: if (tick_cnt == 4'd7) begin
                    state_nx    = bit_s ? IDLE : DATA;
                    tick_cnt_nx = '0;
                    bit_idx_nx  = '0;
                end
                DATA: if (tick_cnt == 4'd15) begin
                    shift_nx   = {bit_s, shift[DATA_BITS-1:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    state_nx   = (bit_idx == LAST_BIT) ? STOP : DATA;
                end
                STOP: if (tick_cnt == 4'd15) begin
                    stop_smp = 1'b1;
                    state_nx = bit_s ? IDLE : BREAK;
                end
                BREAK: if (rx_s) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // A full register accepts a new byte only if it is being drained this very cycle.
    assign load = stop_smp && (!valid_o || ready_i);

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick_cnt_nx;
            bit_idx   <= bit_idx_nx;
            shift     <= shift_nx;
            overrun_o <= stop_smp && !load;
            busy_o    <= state_nx != IDLE;
            if (load) begin
                data_o      <= shift;
                frame_err_o <= !bit_s;
                valid_o     <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that consumes the 16x oversampling tick from the TinyBF baud generator and deserialises 8N1-style frames from the RX pin. It recovers each byte by mid-bit sampling, rejects start-bit glitches and flags framing errors. It presents bytes to the TinyBF core I/O unit through a one-entry valid/ready holding register with overrun detection.

## Interface
Parameters:
- DATA_BITS, default 8: data bits per frame, legal range 5..8, LSB first.

Ports:
- clk_i  in  1  system clock; one clock domain.
- rst_i  in  1  reset, asynchronous, active-low.
- tick_16x_i  in  1  single-cycle pulse at 16x baud rate; all bit timing advances only on cycles where this is 1.
- rx_i  in  1  serial line, idle high, asynchronous to clk_i.
- data_o  out  DATA_BITS  received byte, valid while valid_o=1.
- valid_o  out  1  byte available in holding register.
- ready_i  in  1  consumer accepts; transfer on valid_o && ready_i.
- frame_err_o  out  1  stop bit of held byte sampled low; qualified by valid_o.
- overrun_o  out  1  one-cycle pulse: completed frame discarded because the holding register was full.
- busy_o  out  1  receiver state is not IDLE.

## Operation
- Input synchroniser: two flops on rx_i, both reset to 1. The output rx_s is the only signal the FSM samples.
- Counters: tick_cnt is 4 bits and increments on each tick in START, DATA and STOP, wrapping 15->0. bit_idx is 3 bits.
- FSM states are IDLE, START, DATA, STOP and BREAK. All transitions occur only on tick cycles.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt<=0.
- START, tick with tick_cnt==7 (8 ticks after detection):
  - Sampled bit 1 means a glitch: go to IDLE, no output.
  - Sampled bit 0: go to DATA with tick_cnt<=0 and bit_idx<=0.
- DATA, tick with tick_cnt==15:
  - Shift the sampled bit in at the MSB of a DATA_BITS shift register (LSB-first line order), then bit_idx++.
  - After bit DATA_BITS-1, go to STOP.
- STOP, tick with tick_cnt==15: sample the stop bit and attempt a load (below).
  - Stop bit 1: go to IDLE.
  - Stop bit 0: go to BREAK.
- BREAK: on a tick with rx_s=1, go to IDLE. This prevents a held-low line from producing repeated frames.
- Load at stop sample:
  - If valid_o=0, or valid_o && ready_i in the same cycle: data_o <= shift register, frame_err_o <= !stop_bit, valid_o <= 1.
  - Otherwise keep the old data, data_o and frame_err_o unchanged, and pulse overrun_o for one cycle.
- valid_o clears the cycle after valid_o && ready_i when no load occurs in that cycle.
- A byte with a framing error is still delivered, with frame_err_o=1.

## Timing
- Reset values: data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0. FSM in IDLE, counters 0, synchroniser 11.
- Reset asserted mid-frame aborts immediately. After release, the block waits in IDLE for a new falling edge.
- Sampling offsets from start detection: start bit at 8 ticks, data bit n at 8+16(n+1) ticks, stop bit at 8+16(DATA_BITS+1) ticks.
- rx_i to rx_s latency is 2 clocks.
- All outputs are registered. valid_o, data_o, frame_err_o and overrun_o update on the clock edge that ends the stop-sample tick cycle.
- Ticks with tick_cnt not at a sample point only count.
- tick_16x_i held 0 freezes the FSM and counters. ready_i is still honoured.
- busy_o=1 in START, DATA, STOP and BREAK.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - A 2-bit history register captures rx_s on every tick.
  - The sampled bit is majority(hist[1], hist[0], rx_s), i.e. ticks 13,14,15 for data and stop bits and ticks 5,6,7 for the start bit.
- UART_RX_MAJORITY_EN undefined: the sampled bit is rx_s on the sample tick only, and there is no history register.

## Test plan
- Send 0xA5 (line bits 1,0,1,0,0,1,0,1) with a valid stop and ready_i=1 -> one valid_o cycle, data_o=0xA5, frame_err_o=0, overrun_o never 1.
- rx_i low for 3 ticks then high -> returns to IDLE from START, valid_o stays 0, busy_o falls after tick 8.
- Send 0x3C with stop bit 0, then hold the line low for 40 ticks -> data_o=0x3C, frame_err_o=1, FSM in BREAK with no second frame; after the line rises, the next frame 0x11 is received correctly.
- With ready_i=0, send 0x01 then 0x02 -> data_o stays 0x01, overrun_o pulses once at the second stop sample; raising ready_i clears valid_o.
- With ready_i=0, send 0x55 and 0x66 so that ready_i=1 coincides with the second stop-sample cycle -> data_o=0x66, valid_o stays 1, no overrun.
- Assert rst_i low mid-data on 0xFF, release, then send 0x81 -> only 0x81 is delivered. With UART_RX_MAJORITY_EN defined, a 1-tick low glitch at data tick 14 of bit 0 does not corrupt the byte.
